// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, default address, ACK/NACK levels.
package i2c_pkg;

  localparam logic [6:0] I2C_DEF_ADDR = 7'h68;
  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_PTR_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_TX       = 4'd7,
    ST_MACK     = 4'd8,
    ST_IGNORE   = 4'd9
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;
  logic       scl_s;

  // Two-FF synchronisers plus one history stage per line. Cleared to 0: the
  // bus rising out of reset moves both lines together and is never a START
  // or STOP, since those need SCL high in both the current and history stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '0;
      sda_sync_q <= '0;
      scl_hist_q <= 1'b0;
      sda_hist_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_det  = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a register file: pointer write, data write, burst read.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = I2C_DEF_ADDR,
  parameter bit         PTR_AUTOINC   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL_BUS,
  inout  wire        SDA_BUS,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic       reg_re,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       busy
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (reset),
    .scl_i     (SCL_BUS),
    .sda_i     (SDA_BUS),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;
  logic       inc_pend_q, inc_pend_d;
  logic       rd_load_q;
  logic [7:0] rx_byte;

  // Byte as it stands once the bit sampled on this rise is shifted in.
  assign rx_byte = {shift_q[6:0], sda_s};

  // State and datapath registers; reset also releases SDA asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      inc_pend_q  <= 1'b0;
      rd_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
      inc_pend_q  <= inc_pend_d;
      rd_load_q   <= reg_re_q;
    end
  end

  // Next-state logic: bus events first, then per-state bit handling.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    // Read data is valid the clk after reg_re; capture it then.
    shift_d     = rd_load_q ? reg_rdata : shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    // Write auto-increment lands the clk after the reg_we strobe.
    reg_addr_d  = inc_pend_q ? reg_addr_q + 8'd1 : reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    busy_d      = busy_q;
    inc_pend_d  = 1'b0;

    if (start_det) begin
      // Repeated START keeps busy; an address mismatch will drop it.
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDRESS) begin
                  state_d  = ST_ADDR_ACK;
                  busy_d   = 1'b1;
                  rw_d     = rx_byte[0];
                  reg_re_d = rx_byte[0];
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                reg_addr_d = rx_byte;
                state_d    = ST_PTR_ACK;
              end else begin
                reg_wdata_d = rx_byte;
                reg_we_d    = 1'b1;
                inc_pend_d  = PTR_AUTOINC;
                state_d     = ST_WR_ACK;
              end
            end
          end
        end
        // First fall pulls SDA low, second fall releases it and moves on.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q) begin
                state_d  = ST_TX;
                sda_oe_d = ~shift_q[7];
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WR;
              end
            end
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = ST_MACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              reg_addr_d = PTR_AUTOINC ? reg_addr_q + 8'd1 : reg_addr_q;
              reg_re_d   = 1'b1;
              bit_cnt_d  = '0;
              state_d    = ST_TX;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign SDA_BUS   = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master plus registered read-data model.
module tb_i2c_slave_regfile;

  localparam int Q = 4; // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        SDA_BUS;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_re, reg_we, busy;

  pullup (SDA_BUS);
  assign SDA_BUS = sda_m ? 1'bz : 1'b0;

  i2c_slave_regfile dut (
    .clk       (clk),
    .reset     (reset),
    .SCL_BUS   (scl_m),
    .SDA_BUS   (SDA_BUS),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_re    (reg_re),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Fixed read contents for the addresses the tests touch.
  function automatic logic [7:0] rd_model(input logic [7:0] a);
    case (a)
      8'h75:   return 8'h68;
      8'h3B:   return 8'hA5;
      8'h3C:   return 8'h5A;
      8'h3D:   return 8'h01;
      8'h3E:   return 8'h80;
      8'h3F:   return 8'hFF;
      8'h40:   return 8'h3C;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  // Register-file side: logs strobes, counts DUT-driven lows and busy clks.
  int         we_cnt = 0, re_cnt = 0, low_cnt = 0, busy_cnt = 0;
  logic [7:0] wa [64];
  logic [7:0] wd [64];
  logic [7:0] ra [64];
  always @(posedge clk) begin
    if (reg_we) begin
      wa[we_cnt[5:0]] <= reg_addr;
      wd[we_cnt[5:0]] <= reg_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (reg_re) begin
      ra[re_cnt[5:0]] <= reg_addr;
      re_cnt <= re_cnt + 1;
      reg_rdata <= rd_model(reg_addr);
    end
    if (SDA_BUS === 1'b0 && sda_m) low_cnt <= low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(Q);
    s = SDA_BUS; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(mack, s);
  endtask

  localparam logic [7:0] BURST [6] = '{8'hA5, 8'h5A, 8'h01, 8'h80, 8'hFF, 8'h3C};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         wb, rb, lb, bb;

    // Reset state
    tick(5);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_re", reg_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", SDA_BUS, 1'b1);
    reset = 1'b1;
    tick(5);

    // Write 0x00 to 0x6B
    wb = we_cnt;
    i2c_start();
    send_byte(8'hD0, ack); chk("wr_ack_addr", ack, 1'b0);
    chk("wr_busy", busy, 1'b1);
    send_byte(8'h6B, ack); chk("wr_ack_ptr", ack, 1'b0);
    send_byte(8'h00, ack); chk("wr_ack_data", ack, 1'b0);
    i2c_stop();
    chk("wr_we_cnt", we_cnt - wb, 1);
    chk("wr_we_addr", wa[wb[5:0]], 8'h6B);
    chk("wr_we_data", wd[wb[5:0]], 8'h00);
    chk("wr_ptr_after", reg_addr, 8'h6C);
    chk("wr_busy_after", busy, 1'b0);

    // Single read through repeated START
    rb = re_cnt;
    i2c_start();
    send_byte(8'hD0, ack); chk("rd_ack_addr", ack, 1'b0);
    send_byte(8'h75, ack); chk("rd_ack_ptr", ack, 1'b0);
    i2c_start();
    send_byte(8'hD1, ack); chk("rd_ack_raddr", ack, 1'b0);
    recv_byte(1'b1, d);    chk("rd_data", d, 8'h68);
    i2c_stop();
    chk("rd_re_cnt", re_cnt - rb, 1);
    chk("rd_busy_after", busy, 1'b0);
    chk("rd_ptr_after", reg_addr, 8'h75);

    // Burst read of 6 bytes from 0x3B
    rb = re_cnt;
    i2c_start();
    send_byte(8'hD0, ack);
    send_byte(8'h3B, ack); chk("br_ack_ptr", ack, 1'b0);
    i2c_start();
    send_byte(8'hD1, ack); chk("br_ack_raddr", ack, 1'b0);
    for (int i = 0; i < 6; i++) begin
      recv_byte((i == 5) ? 1'b1 : 1'b0, d);
      chk($sformatf("br_data%0d", i), d, BURST[i]);
      chk($sformatf("br_raddr%0d", i), ra[(rb + i) % 64], 8'h3B + 8'(i));
    end
    chk("br_sda_released", SDA_BUS, 1'b1);
    i2c_stop();
    chk("br_re_cnt", re_cnt - rb, 6);
    chk("br_ptr_after", reg_addr, 8'h40);

    // Address mismatch: bus untouched, no strobes
    wb = we_cnt; rb = re_cnt; lb = low_cnt; bb = busy_cnt;
    i2c_start();
    send_byte(8'hA0, ack); chk("mm_nack_addr", ack, 1'b1);
    send_byte(8'h12, ack); chk("mm_nack_data", ack, 1'b1);
    i2c_stop();
    chk("mm_sda_low", low_cnt - lb, 0);
    chk("mm_we", we_cnt - wb, 0);
    chk("mm_re", re_cnt - rb, 0);
    chk("mm_busy", busy_cnt - bb, 0);
    chk("mm_ptr", reg_addr, 8'h40);

    // Pointer wrap, then STOP mid-byte
    wb = we_cnt;
    i2c_start();
    send_byte(8'hD0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hAA, ack); chk("wrap_ack0", ack, 1'b0);
    send_byte(8'h55, ack); chk("wrap_ack1", ack, 1'b0);
    chk("wrap_we_cnt", we_cnt - wb, 2);
    chk("wrap_addr0", wa[wb[5:0]], 8'hFF);
    chk("wrap_data0", wd[wb[5:0]], 8'hAA);
    chk("wrap_addr1", wa[(wb + 1) % 64], 8'h00);
    chk("wrap_data1", wd[(wb + 1) % 64], 8'h55);
    for (int i = 0; i < 4; i++) bit_x(i[0] ? 1'b0 : 1'b1, ack);
    i2c_stop();
    tick(4);
    chk("abort_we_cnt", we_cnt - wb, 2);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ptr", reg_addr, 8'h01);

    // Reset during TX of 0x01 (third bit drives SDA low)
    i2c_start();
    send_byte(8'hD0, ack);
    send_byte(8'h3D, ack);
    i2c_start();
    send_byte(8'hD1, ack); chk("rr_ack", ack, 1'b0);
    bit_x(1'b1, ack);
    bit_x(1'b1, ack);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2);
    chk("rr_pre_drive", SDA_BUS, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("rr_sda", SDA_BUS, 1'b1);
    chk("rr_addr", reg_addr, 8'h00);
    chk("rr_wdata", reg_wdata, 8'h00);
    chk("rr_we", reg_we, 1'b0);
    chk("rr_re", reg_re, 1'b0);
    chk("rr_busy", busy, 1'b0);
    tick(4);
    reset = 1'b1;
    tick(6);

    // Normal transaction after reset
    wb = we_cnt;
    i2c_start();
    send_byte(8'hD0, ack); chk("post_ack_addr", ack, 1'b0);
    send_byte(8'h10, ack); chk("post_ack_ptr", ack, 1'b0);
    send_byte(8'h77, ack); chk("post_ack_data", ack, 1'b0);
    i2c_stop();
    chk("post_we_cnt", we_cnt - wb, 1);
    chk("post_we_addr", wa[wb[5:0]], 8'h10);
    chk("post_we_data", wd[wb[5:0]], 8'h77);
    chk("post_ptr", reg_addr, 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
